// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO fed by valid/ready,
// drained by a start/data/stop serialiser with back-to-back frame support.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;

    state_t        state_reg;
    logic [CW-1:0] bit_cnt_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          busy_reg;

    logic push;
    logic pop;
    logic bit_last;
    logic fifo_nonempty;

    // ready is driven from the registered level only, so a pop in the same
    // cycle as a full FIFO does not open a slot until the following cycle.
    assign ready         = (level_reg != LW'(FIFO_DEPTH));
    assign push          = valid && ready;
    assign fifo_nonempty = (level_reg != '0);
    assign bit_last      = (bit_cnt_reg == CW'(CLKS_PER_BIT - 1));
    assign pop           = fifo_nonempty &&
                           ((state_reg == IDLE) || ((state_reg == STOP) && bit_last));

    assign tx    = tx_reg;
    assign busy  = busy_reg;
    assign level = level_reg;

    // Storage has no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // tx is registered from the current state, so the line trails the FSM by
    // one cycle uniformly; busy is registered the same way to stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            busy_reg <= (state_reg != IDLE) || fifo_nonempty;
            case (state_reg)
                IDLE: begin
                    tx_reg      <= 1'b1;
                    bit_cnt_reg <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        state_reg <= START;
                    end
                end
                START: begin
                    tx_reg <= 1'b0;
                    if (bit_last) begin
                        bit_cnt_reg <= '0;
                        idx_reg     <= '0;
                        state_reg   <= DATA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    tx_reg <= shift_reg[idx_reg];
                    if (bit_last) begin
                        bit_cnt_reg <= '0;
                        if (idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_last) begin
                        bit_cnt_reg <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            state_reg <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
